// File: rtl/control_pkg.sv
// Shared types and constants for the instruction control unit.
// Optional macro CONTROL_UNIT_SUB_EN adds the Sub instruction.
package control_pkg;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_NOOP,
    S_LOADA,
    S_LOADB,
    S_STORE,
    S_ADD,
    S_HALT
`ifdef CONTROL_UNIT_SUB_EN
    , S_SUB
`endif
  } state_t;

  localparam logic [3:0] NOOP  = 4'h0;
  localparam logic [3:0] STORE = 4'h1;
  localparam logic [3:0] LOAD  = 4'h2;
  localparam logic [3:0] ADD   = 4'h3;
  localparam logic [3:0] SUB   = 4'h4;
  localparam logic [3:0] HALT  = 4'h5;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/control_unit_ir_decode.sv
// Operand field extraction from the 16-bit instruction word.
// Pure wiring; the FSM picks which fields to drive out.
module ir_decode (
  input  logic [15:0] IR,
  output logic [3:0]  op,
  output logic [3:0]  ra,
  output logic [3:0]  rb,
  output logic [3:0]  wa,
  output logic [7:0]  ld_addr,
  output logic [7:0]  st_addr
);

  assign op      = IR[15:12];
  assign ra      = IR[11:8];
  assign rb      = IR[7:4];
  assign wa      = IR[3:0];
  assign ld_addr = IR[11:4];
  assign st_addr = IR[7:0];

endmodule

// File: rtl/control_unit.sv
// Moore control FSM: fetch/decode/execute sequencing for the datapath.
// Define CONTROL_UNIT_SUB_EN to decode opcode 0100 as Sub.
module control_unit
  import control_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IR,
  output logic        PC_clr,
  output logic        PC_up,
  output logic        IR_ld,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RFSelect,
  output logic        RF_W_en,
  output logic [3:0]  RF_W_addr,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  ALUSelect
);

  state_t     state;
  logic [3:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] wa;
  logic [7:0] ld_addr;
  logic [7:0] st_addr;

  ir_decode u_dec (
    .IR      (IR),
    .op      (op),
    .ra      (ra),
    .rb      (rb),
    .wa      (wa),
    .ld_addr (ld_addr),
    .st_addr (st_addr)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= S_INIT;
    end else begin
      unique case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (op)
            NOOP:    state <= S_NOOP;
            STORE:   state <= S_STORE;
            LOAD:    state <= S_LOADA;
            ADD:     state <= S_ADD;
`ifdef CONTROL_UNIT_SUB_EN
            SUB:     state <= S_SUB;
`endif
            HALT:    state <= S_HALT;
            default: state <= S_NOOP;
          endcase
        end
        S_NOOP:   state <= S_FETCH;
        S_LOADA:  state <= S_LOADB;
        S_LOADB:  state <= S_FETCH;
        S_STORE:  state <= S_FETCH;
        S_ADD:    state <= S_FETCH;
`ifdef CONTROL_UNIT_SUB_EN
        S_SUB:    state <= S_FETCH;
`endif
        S_HALT:   state <= S_HALT;
        default:  state <= S_INIT;
      endcase
    end
  end

  // Outputs follow state directly so reset clears them without a clock.
  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = 8'h00;
    D_wr       = 1'b0;
    RFSelect   = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_addr  = 4'h0;
    RF_Ra_addr = 4'h0;
    RF_Rb_addr = 4'h0;
    ALUSelect  = ALU_PASS;
    case (state)
      S_INIT:  PC_clr = 1'b1;
      S_FETCH: begin
        PC_up = 1'b1;
        IR_ld = 1'b1;
      end
      S_LOADA: begin
        D_addr   = ld_addr;
        RFSelect = 1'b1;
      end
      S_LOADB: begin
        D_addr    = ld_addr;
        RFSelect  = 1'b1;
        RF_W_en   = 1'b1;
        RF_W_addr = wa;
      end
      S_STORE: begin
        RF_Ra_addr = ra;
        D_addr     = st_addr;
        D_wr       = 1'b1;
      end
      S_ADD: begin
        RF_Ra_addr = ra;
        RF_Rb_addr = rb;
        RF_W_addr  = wa;
        RF_W_en    = 1'b1;
        ALUSelect  = ALU_ADD;
      end
`ifdef CONTROL_UNIT_SUB_EN
      S_SUB: begin
        RF_Ra_addr = ra;
        RF_Rb_addr = rb;
        RF_W_addr  = wa;
        RF_W_en    = 1'b1;
        ALUSelect  = ALU_SUB;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, asynchronous active-high reset that forces state Init immediately.
REQ-003 SHALL have port IR, input, 16, current instruction: IR[15:12] opcode, IR[11:0] operand fields.
REQ-004 SHALL have port PC_clr, output, 1, clears program counter.
REQ-005 SHALL have port PC_up, output, 1, increments program counter.
REQ-006 SHALL have port IR_ld, output, 1, loads instruction register from instruction memory.
REQ-007 SHALL have port D_addr, output, 8, data memory address.
REQ-008 SHALL have port D_wr, output, 1, data memory write enable.
REQ-009 SHALL have port RFSelect, output, 1, register-file write-data select: 0 = ALU result, 1 = memory read data.
REQ-010 SHALL have port RF_W_en and port RF_W_addr, outputs, widths 1 and 4, register-file write enable and write address.
REQ-011 SHALL have port RF_Ra_addr and port RF_Rb_addr, outputs, 4 each, register-file read addresses.
REQ-012 SHALL have port ALUSelect, output, 3, ALU function: 000 zero/pass, 001 add, 010 sub.

Function
REQ-013 SHALL implement a Moore FSM with states Init, Fetch, Decode, Noop, LoadA, LoadB, Store, Add, Sub, Halt; all outputs decode from current state and IR only.
REQ-014 SHALL drive every output to 0 in any state except where a later REQ asserts it.
REQ-015 SHALL, in Init, assert PC_clr=1 for one cycle, then go to Fetch.
REQ-016 SHALL, in Fetch, assert PC_up=1 and IR_ld=1, then go to Decode.
REQ-017 SHALL, in Decode, assert nothing and branch on IR[15:12]: 0000 Noop, 0001 Store, 0010 LoadA, 0011 Add, 0100 Sub, 0101 Halt; any other opcode goes to Noop.
REQ-018 SHALL, in Noop, assert nothing and return to Fetch.
REQ-019 SHALL, in LoadA, drive D_addr=IR[11:4] and RFSelect=1 with RF_W_en=0, then go to LoadB.
REQ-020 SHALL, in LoadB, hold D_addr=IR[11:4] and RFSelect=1, and assert RF_W_en=1 with RF_W_addr=IR[3:0], then go to Fetch (load latency: 2 cycles after Decode).
REQ-021 SHALL, in Store, drive RF_Ra_addr=IR[11:8], D_addr=IR[7:0] and D_wr=1 for exactly one cycle, then go to Fetch.
REQ-022 SHALL, in Add, drive RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_W_en=1, ALUSelect=001 and RFSelect=0, then go to Fetch.
REQ-023 SHALL, in Sub, drive the same as Add except ALUSelect=010.
REQ-024 SHALL remain in Halt with all outputs 0 until Reset.
REQ-025 SHALL never assert RF_W_en and D_wr in the same cycle.
REQ-026 SHALL fix per-instruction cycle counts: Noop, Store, Add and Sub take 3 cycles from Fetch to Fetch; Load takes 4.

Reset
REQ-027 SHALL, on Reset asserted in any state (including mid-LoadB or Store), enter Init asynchronously and drop D_wr and RF_W_en in the same cycle.
REQ-028 SHALL drive PC_clr=1 with all other outputs 0 while Reset is held, and enter Fetch on the first rising edge after Reset deasserts.

Configuration
REQ-029 SHALL support macro CONTROL_UNIT_SUB_EN: when defined, opcode 0100 decodes to Sub; when undefined, the Sub state is absent, opcode 0100 decodes to Noop, and ALUSelect never takes 010.

Structure
REQ-030 SHALL place the state enum typedef, opcode constants (NOOP, STORE, LOAD, ADD, SUB, HALT) and ALUSelect constants in a shared package, control_pkg.
REQ-031 SHALL split operand-field extraction into one combinational sub-module, ir_decode, instantiated once.

Verification
REQ-032 SHALL cover reset release: Reset 1 to 0 -> one cycle of PC_clr=1, next cycle PC_up=1 and IR_ld=1.
REQ-033 SHALL cover load: IR=16'h2A53 -> LoadA D_addr=8'hA5, RFSelect=1, RF_W_en=0; LoadB RF_W_en=1, RF_W_addr=3; Fetch follows.
REQ-034 SHALL cover add and sub: IR=16'h3123 -> RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=3, ALUSelect=001, RFSelect=0; IR=16'h4123 -> ALUSelect=010 with macro defined, Noop without it.
REQ-035 SHALL cover store: IR=16'h17F0 -> RF_Ra_addr=7, D_addr=8'hF0, D_wr=1 for exactly one cycle.
REQ-036 SHALL cover halt and illegal opcode: IR=16'h5000 -> Halt held for 10 cycles with all outputs 0; IR=16'hF000 -> Noop then Fetch.
REQ-037 SHALL cover mid-operation reset: Reset pulsed during LoadB -> RF_W_en falls without waiting for a clock edge, and state is Init.
